// File: rtl/mul_ctrl.sv
// Controller for a repeated-addition multiplier: loads A and B, then repeats P<=P+A, B<=B-1
// until the datapath reports B==0. A watchdog on the loop count parks the FSM in ERR.
module mul_ctrl #(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned MAX_ITER = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             din_valid,
   input  logic             eqz,
   output logic             ldA,
   output logic             ldB,
   output logic             clrP,
   output logic             ldP,
   output logic             decB,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] iter_cnt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_A = 3'd1;
   localparam logic [2:0] S_LOAD_B = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_ADD    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

   logic [2:0]       state_q;
   logic [2:0]       state_d;
   logic [CNT_W-1:0] iter_d;
   logic [CNT_W-1:0] iter_inc;
   logic             busy_d;
   logic             done_d;
   logic             err_d;

   assign iter_inc = iter_cnt + CNT_W'(1);

   // State, counter and status registers; status flags follow the next state so they
   // line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         iter_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         iter_cnt <= iter_d;
         busy     <= busy_d;
         done     <= done_d;
         err      <= err_d;
      end
   end

   // Next state and datapath strobes; strobes are decoded from the current state.
   always_comb begin
      state_d = state_q;
      iter_d  = iter_cnt;
      ldA     = 1'b0;
      ldB     = 1'b0;
      clrP    = 1'b0;
      ldP     = 1'b0;
      decB    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD_A;
               iter_d  = '0;
            end
         end
         S_LOAD_A: begin
            ldA = din_valid;
            if (din_valid) state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
            ldB  = din_valid;
            clrP = din_valid;
            if (din_valid) state_d = S_CHECK;
         end
         S_CHECK: begin
            state_d = eqz ? S_DONE : S_ADD;
         end
         S_ADD: begin
            ldP     = 1'b1;
            decB    = 1'b1;
            iter_d  = iter_inc;
            state_d = (iter_inc == MAX_CNT) ? S_ERR : S_CHECK;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            if (start) begin
               state_d = S_LOAD_A;
               iter_d  = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over everything and freezes the iteration count.
      if (abort) begin
         state_d = S_IDLE;
         iter_d  = iter_cnt;
         ldA     = 1'b0;
         ldB     = 1'b0;
         clrP    = 1'b0;
         ldP     = 1'b0;
         decB    = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

endmodule

// File: tb/tb_mul_ctrl.sv
// Randomized bench for mul_ctrl: a datapath model plus a scoreboard predicting product,
// iteration count, completion cycle and strobe counts for each operation.
module tb_mul_ctrl;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned MAXI  = 6;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             din_valid = 1'b0;
   logic             eqz;
   logic             ldA, ldB, clrP, ldP, decB, busy, done, err;
   logic [CNT_W-1:0] iter_cnt;

   logic [7:0]  din = '0;
   logic [7:0]  ra = '0;
   logic [7:0]  rb = '0;
   logic [15:0] rp = '0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      bit          is_err;
      logic [15:0] p;
      int          iter;
      int          t;
   } exp_t;
   exp_t sb[$];

   mul_ctrl #(.CNT_W(CNT_W), .MAX_ITER(MAXI)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .din_valid(din_valid),
      .eqz(eqz), .ldA(ldA), .ldB(ldB), .clrP(clrP), .ldP(ldP), .decB(decB),
      .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath: A, B, P registers and the B==0 comparator.
   assign eqz = (rb == 8'd0);
   always @(posedge clk) begin
      if (ldA) ra <= din;
      if (ldB) rb <= din;
      if (decB) rb <= rb - 8'd1;
      if (clrP) rp <= 16'd0;
      if (ldP) rp <= rp + 16'(ra);
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Monitor: tallies strobes per operation and checks each completion against the scoreboard.
   initial begin : monitor
      int n_lda, n_ldb, n_clrp, n_ldp, n_decb, n_bad;
      bit err_prev;
      exp_t e;
      n_lda = 0; n_ldb = 0; n_clrp = 0; n_ldp = 0; n_decb = 0; n_bad = 0; err_prev = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (start && (!busy || err)) begin
               n_lda = 0; n_ldb = 0; n_clrp = 0; n_ldp = 0; n_decb = 0; n_bad = 0;
            end
            n_lda  += int'(ldA);
            n_ldb  += int'(ldB);
            n_clrp += int'(clrP);
            n_ldp  += int'(ldP);
            n_decb += int'(decB);
            if (((ldA || ldB) && (ldP || decB)) || (done && (ldA || ldB || clrP || ldP || decB)))
               n_bad++;
            if (done || (err && !err_prev)) begin
               if (sb.size() == 0) begin
                  chk("sb_unexpected_completion", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("kind_err", 32'(err), 32'(e.is_err));
                  chk("kind_done", 32'(done), 32'(!e.is_err));
                  chk("complete_cycle", 32'(cyc), 32'(e.t));
                  chk("iter_cnt", 32'(iter_cnt), 32'(e.iter));
                  if (!e.is_err) chk("product", 32'(rp), 32'(e.p));
                  chk("ldA_count", 32'(n_lda), 32'd1);
                  chk("ldB_count", 32'(n_ldb), 32'd1);
                  chk("clrP_count", 32'(n_clrp), 32'd1);
                  chk("ldP_count", 32'(n_ldp), 32'(e.iter));
                  chk("decB_count", 32'(n_decb), 32'(e.iter));
                  chk("strobe_overlap", 32'(n_bad), 32'd0);
               end
            end
            err_prev = err;
         end else begin
            err_prev = 0;
         end
      end
   end

   // One operation with s1/s2 stall cycles in LOAD_A/LOAD_B; prediction pushed at issue.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int s1, input int s2);
      exp_t e;
      bit   hold2;
      bit   got;
      int   nload;
      hold2 = 1'($urandom % 2);
      nload = s1 + s2 + 2;
      @(posedge clk); #1;
      e.is_err = (int'(b) >= MAXI);
      e.p      = 16'(a) * 16'(b);
      e.iter   = e.is_err ? MAXI : int'(b);
      e.t      = cyc + (e.is_err ? (s1 + s2 + 3 + 2 * MAXI) : (2 * int'(b) + 4 + s1 + s2));
      sb.push_back(e);
      start = 1'b1;
      din_valid = 1'b0;
      for (int k = 1; k <= nload; k++) begin
         @(posedge clk); #1;
         start     = (k == 1) && hold2;
         din_valid = (k == s1 + 1) || (k == nload);
         din       = (k <= s1 + 1) ? a : b;
      end
      @(posedge clk); #1;
      start = 1'b0;
      din_valid = 1'($urandom % 2);
      din = 8'($urandom);
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (done || err) got = 1;
      end
      chk("completion_timeout", 32'(got), 32'd1);
      din_valid = 1'b0;
      if (!e.is_err) begin
         @(negedge clk);
         chk("done_single_pulse", 32'(done), 32'd0);
         chk("idle_after_done", 32'(busy), 32'd0);
         chk("iter_hold_after_done", 32'(iter_cnt), 32'(e.iter));
      end
   endtask

   // Start with A=7, B=5, no stalls; returns at posedge+1 of cycle 'upto'.
   task automatic start_to_cycle(input int upto);
      @(posedge clk); #1;
      start = 1'b1; din_valid = 1'b0;
      for (int k = 1; k <= upto; k++) begin
         @(posedge clk); #1;
         start     = 1'b0;
         din_valid = (k == 1) || (k == 2);
         din       = (k == 1) ? 8'd7 : 8'd5;
      end
   endtask

   initial begin
      @(posedge clk); #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_iter", 32'(iter_cnt), 32'd0);
      chk("rst_strobes", 32'({ldA, ldB, clrP, ldP, decB}), 32'd0);
      @(negedge clk); #2;
      rst_n = 1'b1;

      run_op(8'd9, 8'd3, 0, 0);
      run_op(8'd200, 8'd0, 0, 0);
      run_op(8'd17, 8'd4, 2, 1);
      run_op(8'd33, 8'd10, 0, 0);
      chk("err_held", 32'(err), 32'd1);
      run_op(8'd5, 8'd2, 0, 0);

      // Abort during the second ADD (cycle 6).
      start_to_cycle(6);
      abort = 1'b1;
      @(negedge clk);
      chk("abort_ldP", 32'(ldP), 32'd0);
      chk("abort_decB", 32'(decB), 32'd0);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_iter_hold", 32'(iter_cnt), 32'd1);

      // start and abort together in IDLE.
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_abort_idle", 32'(busy), 32'd0);

      // Asynchronous reset off-edge during the second ADD.
      start_to_cycle(6);
      @(negedge clk);
      chk("pre_reset_ldP", 32'(ldP), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_busy", 32'(busy), 32'd0);
      chk("areset_strobes", 32'({ldP, decB}), 32'd0);
      chk("areset_iter", 32'(iter_cnt), 32'd0);
      @(negedge clk); #2;
      rst_n = 1'b1;

      for (int n = 0; n < 40; n++) begin
         run_op(8'($urandom), 8'($urandom_range(0, 9)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
